// File: rtl/fifo_v4.sv
// rtl/fifo_v4.sv - parametrised valid/ready FIFO with watermarks and selectable overflow policy
module fifo_v4 #(
    parameter logic FALL_THROUGH  = 1'b0,
    parameter int   DATA_WIDTH    = 32,
    parameter int   DEPTH         = 8,
    parameter int   OVERFLOW_MODE = 0,
    parameter int   CNT_WIDTH     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [CNT_WIDTH-1:0]  af_thresh_i,
    input  logic [CNT_WIDTH-1:0]  ae_thresh_i,
    output logic [CNT_WIDTH-1:0]  usage_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic [15:0]           drop_cnt_o
);
    localparam int                   PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);

    if (DEPTH < 2) begin : g_chk_depth
        $error("fifo_v4: DEPTH must be >= 2");
    end
    if (OVERFLOW_MODE < 0 || OVERFLOW_MODE > 2) begin : g_chk_mode
        $error("fifo_v4: OVERFLOW_MODE must be 0, 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  is_full;
    logic                  is_empty;
    logic                  bypass;
    logic                  pop;
    logic                  wr_en;
    logic                  rd_adv;
    logic                  ovf_evt;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Overwrite-oldest on a full FIFO advances the read pointer whether or not the
    // head is popped; only an unpopped overwrite loses data.
    always_comb begin
        is_empty = (count == '0);
        is_full  = (count == FULL_CNT);
        bypass   = FALL_THROUGH && is_empty && valid_i && ready_i;
        pop      = !is_empty && ready_i;
        wr_en    = !flush_i && valid_i && !bypass && (!is_full || OVERFLOW_MODE == 2);
        rd_adv   = !flush_i && (pop || (OVERFLOW_MODE == 2 && is_full && valid_i));
        ovf_evt  = !flush_i && valid_i && is_full &&
                   (OVERFLOW_MODE == 1 || (OVERFLOW_MODE == 2 && !pop));
    end

    assign ready_o        = (OVERFLOW_MODE == 0) ? !is_full : 1'b1;
    assign valid_o        = !is_empty || (FALL_THROUGH && valid_i);
    assign data_o         = (FALL_THROUGH && is_empty) ? data_i : mem[rd_ptr];
    assign usage_o        = count;
    assign full_o         = is_full;
    assign empty_o        = is_empty;
    assign almost_full_o  = (count >= af_thresh_i);
    assign almost_empty_o = (count <= ae_thresh_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_adv) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_en && !rd_adv) begin
                count <= count + 1'b1;
            end else if (rd_adv && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // A loss in the same cycle as a clear restarts the tally at one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (ovf_evt) begin
            overflow_o <= 1'b1;
            if (clr_err_i) begin
                drop_cnt_o <= 16'd1;
            end else if (drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end else if (clr_err_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end
    end

    a_no_push_when_not_ready : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (valid_i && !ready_o) |-> !wr_en
    ) else $error("fifo_v4: push accepted while ready_o=0");

    a_count_in_range : assert property (
        @(posedge clk_i) disable iff (!rst_ni) count <= FULL_CNT
    ) else $error("fifo_v4: count exceeds DEPTH");
endmodule

// File: tb/tb_fifo_v4.sv
// tb/tb_fifo_v4.sv - table-driven bench for fifo_v4 across depth, overflow mode and fall-through variants
module tb_fifo_v4;
    typedef struct {
        int rst;
        int d;
        int fl, cl, vi, di, ri;
        int eu, er, ev, ed, ef, ee, eaf, eae, eov, edr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, clr, vin, rin;
    logic [7:0] din;
    logic [3:0] af = 4'd6;
    logic [3:0] ae = 4'd2;

    logic [3:0]  ready_w, valid_w, full_w, empty_w, af_w, ae_w, ovf_w;
    logic [7:0]  data_w [4];
    logic [15:0] drop_w [4];
    logic [2:0]  usage0;
    logic [3:0]  usage1, usage2, usage3;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5), .OVERFLOW_MODE(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr),
        .data_i(din), .valid_i(vin), .ready_o(ready_w[0]),
        .data_o(data_w[0]), .valid_o(valid_w[0]), .ready_i(rin),
        .af_thresh_i(af[2:0]), .ae_thresh_i(ae[2:0]), .usage_o(usage0),
        .full_o(full_w[0]), .empty_o(empty_w[0]), .almost_full_o(af_w[0]),
        .almost_empty_o(ae_w[0]), .overflow_o(ovf_w[0]), .drop_cnt_o(drop_w[0]));

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8), .OVERFLOW_MODE(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr),
        .data_i(din), .valid_i(vin), .ready_o(ready_w[1]),
        .data_o(data_w[1]), .valid_o(valid_w[1]), .ready_i(rin),
        .af_thresh_i(af), .ae_thresh_i(ae), .usage_o(usage1),
        .full_o(full_w[1]), .empty_o(empty_w[1]), .almost_full_o(af_w[1]),
        .almost_empty_o(ae_w[1]), .overflow_o(ovf_w[1]), .drop_cnt_o(drop_w[1]));

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8), .OVERFLOW_MODE(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr),
        .data_i(din), .valid_i(vin), .ready_o(ready_w[2]),
        .data_o(data_w[2]), .valid_o(valid_w[2]), .ready_i(rin),
        .af_thresh_i(af), .ae_thresh_i(ae), .usage_o(usage2),
        .full_o(full_w[2]), .empty_o(empty_w[2]), .almost_full_o(af_w[2]),
        .almost_empty_o(ae_w[2]), .overflow_o(ovf_w[2]), .drop_cnt_o(drop_w[2]));

    fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(8), .OVERFLOW_MODE(0)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_err_i(clr),
        .data_i(din), .valid_i(vin), .ready_o(ready_w[3]),
        .data_o(data_w[3]), .valid_o(valid_w[3]), .ready_i(rin),
        .af_thresh_i(af), .ae_thresh_i(ae), .usage_o(usage3),
        .full_o(full_w[3]), .empty_o(empty_w[3]), .almost_full_o(af_w[3]),
        .almost_empty_o(ae_w[3]), .overflow_o(ovf_w[3]), .drop_cnt_o(drop_w[3]));

    function automatic int usage_of(input int d);
        case (d)
            0:       return int'(usage0);
            1:       return int'(usage1);
            2:       return int'(usage2);
            default: return int'(usage3);
        endcase
    endfunction

    // Expected -1 means "don't care"; status flags are derived from expected usage.
    task automatic add(input int r, input int d, input int fl, input int cl, input int vi,
                       input int di, input int ri, input int eu, input int er, input int ev,
                       input int ed, input int eov, input int edr);
        vec_t v;
        int   dep;
        dep   = (d == 0) ? 5 : 8;
        v.rst = r;  v.d = d;  v.fl = fl;  v.cl = cl;  v.vi = vi;  v.di = di;  v.ri = ri;
        v.eu  = eu; v.er = er; v.ev = ev; v.ed = ed; v.eov = eov; v.edr = edr;
        v.ef  = (eu < 0) ? -1 : int'(eu == dep);
        v.ee  = (eu < 0) ? -1 : int'(eu == 0);
        v.eaf = (eu < 0) ? -1 : int'(eu >= 6);
        v.eae = (eu < 0) ? -1 : int'(eu <= 2);
        vq.push_back(v);
    endtask

    task automatic cmp(input string nm, input int idx, input int act, input int want);
        if (want >= 0) begin
            n_cmp++;
            if (act != want) begin
                n_bad++;
                $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, want);
            end
        end
    endtask

    task automatic idle();
        flush = 1'b0; clr = 1'b0; vin = 1'b0; rin = 1'b0; din = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_vec(input int i);
        vec_t v;
        v = vq[i];
        cmp("usage", i, usage_of(v.d), v.eu);
        cmp("ready", i, int'(ready_w[v.d]), v.er);
        cmp("valid", i, int'(valid_w[v.d]), v.ev);
        cmp("data", i, int'(data_w[v.d]), v.ed);
        cmp("full", i, int'(full_w[v.d]), v.ef);
        cmp("empty", i, int'(empty_w[v.d]), v.ee);
        cmp("almost_full", i, int'(af_w[v.d]), v.eaf);
        cmp("almost_empty", i, int'(ae_w[v.d]), v.eae);
        cmp("overflow", i, int'(ovf_w[v.d]), v.eov);
        cmp("drop_cnt", i, int'(drop_w[v.d]), v.edr);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // DEPTH=5 back-pressure: 7 offered, 5 stored, pop while full does not admit a push
        add(1,0,0,0,1,1,0, 0,1,0,-1,0,0);
        add(0,0,0,0,1,2,0, 1,1,1,1,0,0);
        add(0,0,0,0,1,3,0, 2,1,1,1,0,0);
        add(0,0,0,0,1,4,0, 3,1,1,1,0,0);
        add(0,0,0,0,1,5,0, 4,1,1,1,0,0);
        add(0,0,0,0,1,6,0, 5,0,1,1,0,0);
        add(0,0,0,0,1,7,1, 5,0,1,1,0,0);
        for (int k = 2; k <= 5; k++) add(0,0,0,0,0,0,1, 6-k,1,1,k,0,0);
        add(0,0,0,0,0,0,0, 0,1,0,-1,0,0);
        add(0,0,0,0,1,8'h0A,0, 0,1,0,-1,0,0);
        add(0,0,0,0,1,8'h0B,1, 1,1,1,8'h0A,0,0);
        add(0,0,0,0,0,0,1, 1,1,1,8'h0B,0,0);
        add(0,0,0,0,0,0,0, 0,1,0,-1,0,0);

        // Watermarks af=6 ae=2 while filling, then steady push+pop at usage 4
        add(1,1,0,0,1,8'h10,0, 0,1,0,-1,0,0);
        for (int u = 1; u < 8; u++) add(0,1,0,0,1,8'h10+u,0, u,1,1,8'h10,0,0);
        add(0,1,0,0,0,0,0, 8,1,1,8'h10,0,0);
        for (int k = 0; k < 4; k++) add(0,1,0,0,0,0,1, 8-k,1,1,8'h10+k,0,0);
        for (int k = 0; k < 3; k++) add(0,1,0,0,1,8'h20+k,1, 4,1,1,8'h14+k,0,0);
        add(0,1,0,0,0,0,0, 4,1,1,8'h17,0,0);

        // Drop-newest: three drops, clear colliding with a drop, drop during a pop
        add(1,1,0,0,1,8'hA0,0, 0,1,0,-1,0,0);
        for (int u = 1; u < 8; u++) add(0,1,0,0,1,8'hA0+u,0, u,1,1,8'hA0,0,0);
        add(0,1,0,0,1,8'hFF,0, 8,1,1,8'hA0,0,0);
        add(0,1,0,0,1,8'hFF,0, 8,1,1,8'hA0,1,1);
        add(0,1,0,0,1,8'hFF,0, 8,1,1,8'hA0,1,2);
        add(0,1,0,1,1,8'hFF,0, 8,1,1,8'hA0,1,3);
        add(0,1,0,1,0,0,0, 8,1,1,8'hA0,1,1);
        add(0,1,0,0,1,8'hEE,1, 8,1,1,8'hA0,0,0);
        for (int k = 1; k < 8; k++) add(0,1,0,0,0,0,1, 8-k,1,1,8'hA0+k,1,1);
        add(0,1,0,0,0,0,0, 0,1,0,-1,1,1);

        // Flush at usage 3 with push and pop asserted; sticky error survives
        add(0,1,0,0,1,8'h31,0, 0,1,0,-1,1,1);
        add(0,1,0,0,1,8'h32,0, 1,1,1,8'h31,1,1);
        add(0,1,0,0,1,8'h33,0, 2,1,1,8'h31,1,1);
        add(0,1,1,0,1,8'h34,1, 3,1,1,8'h31,1,1);
        add(0,1,0,0,0,0,0, 0,1,0,-1,1,1);
        add(0,1,0,0,1,8'h35,0, 0,1,0,-1,1,1);
        add(0,1,0,0,0,0,0, 1,1,1,8'h35,1,1);

        // Overwrite-oldest: 8 and 9 displace 0 and 1; push with pop is not an overflow
        add(1,2,0,0,1,0,0, 0,1,0,-1,0,0);
        for (int u = 1; u < 8; u++) add(0,2,0,0,1,u,0, u,1,1,0,0,0);
        add(0,2,0,0,1,8,0, 8,1,1,0,0,0);
        add(0,2,0,0,1,9,0, 8,1,1,1,1,1);
        add(0,2,0,0,1,8'h0A,1, 8,1,1,2,1,2);
        for (int k = 0; k < 8; k++) add(0,2,0,0,0,0,1, 8-k,1,1,3+k,1,2);
        add(0,2,0,0,0,0,0, 0,1,0,-1,1,2);

        // Fall-through: bypass when ready, store when not
        add(1,3,0,0,1,8'h55,1, 0,1,1,8'h55,0,0);
        add(0,3,0,0,0,0,0, 0,1,0,-1,0,0);
        add(0,3,0,0,1,8'h66,0, 0,1,1,8'h66,0,0);
        add(0,3,0,0,0,0,0, 1,1,1,8'h66,0,0);
        add(0,3,0,0,1,8'h77,1, 1,1,1,8'h66,0,0);
        add(0,3,0,0,0,0,0, 1,1,1,8'h77,0,0);
        add(0,3,0,0,0,0,1, 1,1,1,8'h77,0,0);
        add(0,3,0,0,0,0,0, 0,1,0,-1,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst != 0) do_reset();
            @(negedge clk);
            flush = (vq[i].fl != 0);
            clr   = (vq[i].cl != 0);
            vin   = (vq[i].vi != 0);
            rin   = (vq[i].ri != 0);
            din   = 8'(vq[i].di);
            #2;
            check_vec(i);
        end

        // Drop counter saturation, then asynchronous reset mid-stream
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vin = 1'b1;
            din = 8'(k);
        end
        for (int k = 0; k < 65540; k++) @(negedge clk);
        #2;
        cmp("sat_drop_cnt", -1, int'(drop_w[1]), 16'hFFFF);
        cmp("sat_overflow", -1, int'(ovf_w[1]), 1);
        cmp("sat_usage", -1, usage_of(1), 8);
        rst_n = 1'b0;
        #1;
        cmp("rst_usage", -1, usage_of(1), 0);
        cmp("rst_empty", -1, int'(empty_w[1]), 1);
        cmp("rst_full", -1, int'(full_w[1]), 0);
        cmp("rst_valid", -1, int'(valid_w[1]), 0);
        cmp("rst_ready", -1, int'(ready_w[1]), 1);
        cmp("rst_overflow", -1, int'(ovf_w[1]), 0);
        cmp("rst_drop_cnt", -1, int'(drop_w[1]), 0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_v4.md
Name: fifo_v4

Overview:
Parametrised successor FIFO for the interrupt-controller datapath (event/IRQ-ID queues behind the APB slave). It adds valid/ready handshakes on both sides, a full-width occupancy count, programmable almost-full/almost-empty watermarks and selectable overflow policies. Overflow policies are back-pressure, drop-newest and overwrite-oldest, with a sticky error flag and a drop counter for the register file.

Parameters:
FALL_THROUGH, 1'b0, when 1 an empty FIFO forwards data_i to data_o in the same cycle.
DATA_WIDTH, 32, payload width in bits.
DEPTH, 8, number of entries. Must be >= 2; any value is allowed, not only powers of two.
OVERFLOW_MODE, 0, overflow policy: 0 = back-pressure, 1 = drop newest, 2 = overwrite oldest.
CNT_WIDTH, $clog2(DEPTH+1), derived count width. Do not override.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
flush_i  in  1  synchronous clear of contents.
clr_err_i  in  1  clears overflow_o and drop_cnt_o.
data_i  in  DATA_WIDTH  write payload.
valid_i  in  1  write request.
ready_o  out  1  write accepted when valid_i & ready_o.
data_o  out  DATA_WIDTH  head payload.
valid_o  out  1  head valid.
ready_i  in  1  pop when valid_o & ready_i.
af_thresh_i  in  CNT_WIDTH  almost-full watermark.
ae_thresh_i  in  CNT_WIDTH  almost-empty watermark.
usage_o  out  CNT_WIDTH  entries stored, 0..DEPTH.
full_o  out  1  usage == DEPTH.
empty_o  out  1  usage == 0.
almost_full_o  out  1  usage >= af_thresh_i.
almost_empty_o  out  1  usage <= ae_thresh_i.
overflow_o  out  1  sticky overflow flag.
drop_cnt_o  out  16  saturating count of lost entries.

Behaviour:
- Reset (async, rst_ni=0): pointers=0, count=0, overflow_o=0, drop_cnt_o=0. Resulting outputs: usage_o=0, empty_o=1, full_o=0, valid_o=0 (unless FALL_THROUGH & valid_i), ready_o=1. Storage array is not reset.
- Status outputs are decoded from the registered count and are combinational in the watermark inputs.
- data_o is don't-care while valid_o=0.
- Pop: valid_o = (count != 0). On pop, the read pointer advances and wraps DEPTH-1 -> 0. Latency: data is visible on data_o the cycle after it is accepted.
- Push with not full: data is written at the write pointer, which advances and wraps DEPTH-1 -> 0.
- Push and pop in the same cycle with 0 < count < DEPTH: both pointers advance and count is unchanged.
- Mode 0: ready_o = ~full_o. A push while full is impossible; with count == DEPTH a simultaneous pop does not enable a push that cycle.
- Mode 1: ready_o = 1. valid_i while full is dropped, even if a pop occurs the same cycle. A drop sets overflow_o and increments drop_cnt_o. Storage and write pointer are unchanged.
- Mode 2: ready_o = 1. valid_i while full:
  - Data overwrites the oldest entry; both pointers advance; count stays DEPTH.
  - If no pop that cycle, overflow_o is set and drop_cnt_o increments.
  - If a pop occurs that cycle, the head is consumed normally and there is no overflow.
- FALL_THROUGH=1 with count == 0 and valid_i:
  - valid_o=1 and data_o=data_i combinationally.
  - If ready_i, the item bypasses storage with no state change.
  - If not ready_i, it is stored normally.
  - empty_o still reflects the registered count (1).
- flush_i: highest priority. Next cycle pointers and count are 0; any push/pop in the flush cycle is ignored. overflow_o and drop_cnt_o are not affected by flush_i.
- clr_err_i: next cycle overflow_o=0 and drop_cnt_o=0. If an overflow event occurs in the same cycle, the event wins: overflow_o=1, drop_cnt_o=1.
- drop_cnt_o saturates at 16'hFFFF.
- Elaboration-time checks: DEPTH >= 2 and OVERFLOW_MODE <= 2.
- Simulation assertions: no push while ready_o=0 is accepted; count never exceeds DEPTH.

Test Plan:
1. DEPTH=5, mode 0: push 7 words 0x1..0x7 with ready_i=0 -> 5 accepted; ready_o=0 and full_o=1 after the 5th; usage_o=5; draining yields 0x1..0x5 in order, exercising pointer wrap on refill.
2. DEPTH=8, af=6, ae=2: fill one per cycle -> almost_empty_o=1 for usage 0..2; almost_full_o=1 from usage 6; full_o at 8; continuous push+pop at usage 4 holds usage_o=4.
3. Mode 1, full FIFO of 0xA0..0xA7: push 0xFF for 3 cycles -> overflow_o=1, drop_cnt_o=3, contents still 0xA0..0xA7. Then clr_err_i together with a 4th drop -> overflow_o=1, drop_cnt_o=1.
4. Mode 2, full FIFO of 0..7: push 8 and 9 -> pops return 2..9 and drop_cnt_o=2. A push on a full FIFO with a simultaneous pop -> overflow_o unchanged.
5. FALL_THROUGH=1, empty FIFO, valid_i=1, data_i=0x55, ready_i=1 -> valid_o=1 and data_o=0x55 the same cycle; usage_o stays 0.
6. Usage 3 with flush_i=1, valid_i=1 and ready_i=1 simultaneously -> next cycle usage_o=0, empty_o=1, overflow_o unchanged. Asserting rst_ni low mid-stream -> all outputs return to reset values immediately.
